// File: rtl/motor_stepper_ctrl_pkg.sv
// Shared definitions for the stepper controller: FSM state encoding,
// one-hot coil drive patterns, default parameter values and the
// phase-index to coil-pattern mapping.
package motor_stepper_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RAMP  = 3'd1,
      ST_RUN   = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FAULT = 3'd4
   } stepState_t;

   localparam logic [3:0] COIL_OFF = 4'b0000;
   localparam logic [3:0] COIL_A   = 4'b0001;
   localparam logic [3:0] COIL_B   = 4'b0010;
   localparam logic [3:0] COIL_C   = 4'b0100;
   localparam logic [3:0] COIL_D   = 4'b1000;

   localparam int DEF_RAMP_START = 8;
   localparam int DEF_HOLD_TICKS = 10;
   localparam int DEF_DEB_CYCLES = 16;
   localparam int DEF_CNT_W      = 16;

   function automatic logic [3:0] coilFor(input logic [1:0] idx);
      logic [3:0] pattern;
      case (idx)
         2'd0:    pattern = COIL_A;
         2'd1:    pattern = COIL_B;
         2'd2:    pattern = COIL_C;
         default: pattern = COIL_D;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/motor_stepper_ctrl_debounce.sv
// sensor_debounce: two-flop synchroniser followed by a stability counter.
// The output takes the synchronised value only after DEB_CYCLES consecutive
// samples that differ from the current output.
// Ports:
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous, active-high
//   in    in  1  raw asynchronous input
//   out   out 1  debounced level
module sensor_debounce
   import motor_stepper_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         out   <= 1'b0;
      end else begin
         sync1 <= in;
         sync2 <= sync1;
         // Any sample agreeing with the output restarts the stability window.
         if (sync2 == out) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            out <= sync2;
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/motor_stepper_ctrl.sv
// motor_stepper_ctrl: drives a 4-coil unipolar stepper with a speed ramp
// while run is high, holds the coils energised for a while after run
// falls, and latches a de-energised fault when the debounced obstacle
// sensor trips.
// Ports:
//   clk        in  1      rising-edge clock
//   reset      in  1      synchronous, active-high
//   step_tick  in  1      one-cycle base step-rate enable
//   run        in  1      1 = motor should turn
//   dir        in  1      1 = forward, 0 = reverse
//   sensor     in  1      raw asynchronous obstacle sensor, active-high
//   coils      out 4      one-hot coil drive, 0000 = de-energised
//   busy       out 1      high in RAMP, RUN, HOLD
//   fault      out 1      high in FAULT
//   steps      out CNT_W  total steps taken, wrapping
module motor_stepper_ctrl
   import motor_stepper_ctrl_pkg::*;
#(
   parameter int RAMP_START = DEF_RAMP_START,
   parameter int HOLD_TICKS = DEF_HOLD_TICKS,
   parameter int DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step_tick,
   input  logic             run,
   input  logic             dir,
   input  logic             sensor,
   output logic [3:0]       coils,
   output logic             busy,
   output logic             fault,
   output logic [CNT_W-1:0] steps
);

   localparam int DIV_W  = $clog2(RAMP_START + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
   localparam logic [DIV_W-1:0]  DIV_START = DIV_W'(RAMP_START);
   localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [CNT_W-1:0]  STEP_ONE  = CNT_W'(1);

   stepState_t        state, stateNext;
   logic [1:0]        idx, idxNext;
   logic [CNT_W-1:0]  stepsNext;
   logic [DIV_W-1:0]  div, divNext;
   logic [DIV_W-1:0]  tickCnt, tickCntNext;
   logic [HOLD_W-1:0] holdCnt, holdCntNext;
   logic              stepEvent;
   logic              sensorDb;
   logic              energised;

   sensor_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
   ) uDebounce (
      .clk  (clk),
      .reset(reset),
      .in   (sensor),
      .out  (sensorDb)
   );

   always_comb begin
      stateNext   = state;
      idxNext     = idx;
      stepsNext   = steps;
      divNext     = div;
      tickCntNext = tickCnt;
      holdCntNext = holdCnt;
      stepEvent   = step_tick && (tickCnt == div - DIV_ONE);

      case (state)
         ST_IDLE: begin
            if (sensorDb) begin
               stateNext = ST_FAULT;
            end else if (run) begin
               stateNext   = ST_RAMP;
               divNext     = DIV_START;
               tickCntNext = '0;
            end
         end
         ST_RAMP, ST_RUN: begin
            // Fault and run-falling both pre-empt a step due on the same edge.
            if (sensorDb) begin
               stateNext = ST_FAULT;
            end else if (!run) begin
               stateNext   = ST_HOLD;
               holdCntNext = '0;
            end else if (stepEvent) begin
               tickCntNext = '0;
               idxNext     = dir ? idx + 2'd1 : idx - 2'd1;
               stepsNext   = steps + STEP_ONE;
               if (state == ST_RAMP) begin
                  // div never drops below 1, so RAMP_START=1 ramps straight to RUN.
                  if (div > DIV_ONE) begin
                     divNext = div - DIV_ONE;
                  end
                  if (divNext == DIV_ONE) begin
                     stateNext = ST_RUN;
                  end
               end
            end else if (step_tick) begin
               tickCntNext = tickCnt + DIV_ONE;
            end
         end
         ST_HOLD: begin
            if (sensorDb) begin
               stateNext = ST_FAULT;
            end else if (run) begin
               stateNext   = ST_RAMP;
               divNext     = DIV_START;
               tickCntNext = '0;
            end else if (step_tick) begin
               if (holdCnt == HOLD_LAST) begin
                  stateNext = ST_IDLE;
               end else begin
                  holdCntNext = holdCnt + HOLD_ONE;
               end
            end
         end
         ST_FAULT: begin
            if (!run && !sensorDb) begin
               stateNext = ST_IDLE;
            end
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase

      energised = (stateNext == ST_RAMP) || (stateNext == ST_RUN) ||
                  (stateNext == ST_HOLD);
   end

   // Outputs are registered from next-state values so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         idx     <= 2'd0;
         steps   <= '0;
         div     <= DIV_START;
         tickCnt <= '0;
         holdCnt <= '0;
         coils   <= COIL_OFF;
         busy    <= 1'b0;
         fault   <= 1'b0;
      end else begin
         state   <= stateNext;
         idx     <= idxNext;
         steps   <= stepsNext;
         div     <= divNext;
         tickCnt <= tickCntNext;
         holdCnt <= holdCntNext;
         coils   <= energised ? coilFor(idxNext) : COIL_OFF;
         busy    <= energised;
         fault   <= (stateNext == ST_FAULT);
      end
   end

endmodule
